sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
Round-robin arbiter and sequencer that shares one square_root engine among N_REQ requesters. It accepts one operand at a time and drives the engine's START/DONE/AVAILABLE handshake. It returns each result, or a timeout error, to the originating requester as a one-cycle tagged response. It sits between the requesting datapath blocks and the single square_root instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 32, operand/result width; matches engine in/out
TIMEOUT, 64, max cycles in BUSY awaiting sqrt_done before abort (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request pending
req_data  input  N_REQ*DATA_W  operands, requester i in bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot, one-cycle accept pulse
rsp_valid  output  1  one-cycle response strobe
rsp_id  output  $clog2(N_REQ)  requester index of response
rsp_data  output  DATA_W  engine result (0 on error)
rsp_err  output  1  timeout flag, valid with rsp_valid
busy  output  1  high in any state except IDLE
sqrt_in  output  DATA_W  operand to engine
sqrt_start  output  1  engine START
sqrt_out  input  DATA_W  engine result
sqrt_done  input  1  engine DONE
sqrt_available  input  1  engine AVAILABLE

Behaviour:
- All outputs registered. Reset (rstn=0, asynchronous) clears every output to 0, state=IDLE, timeout counter=0, last_grant=N_REQ-1. Requester 0 therefore has first priority after reset.
- Reset mid-operation: sqrt_start drops immediately. No response is issued for the in-flight request.
- FSM states: IDLE, BUSY, RELEASE, RESP.
- IDLE: when any req_valid=1 and sqrt_available=1, grant g = first set bit searching last_grant+1, last_grant+2, ... with wrap modulo N_REQ.
  - Next edge: req_ready[g]=1 for exactly one cycle; latch operand to sqrt_in; latch g to rsp_id; set sqrt_start=1; state -> BUSY.
  - If sqrt_available=0, no grant is made and requests wait.
- Request rules: req_valid may deassert before acceptance without side effects. A requester must hold req_data stable while req_valid=1. No request is accepted outside IDLE.
- BUSY: sqrt_start held 1; the counter increments every BUSY cycle.
  - sqrt_done=1: latch sqrt_out into rsp_data, rsp_err=0, state -> RELEASE.
  - Else, counter reaching TIMEOUT: rsp_data=0, rsp_err=1, state -> RELEASE.
  - sqrt_done wins if it coincides with the timeout cycle.
- RELEASE: sqrt_start=0. Wait until sqrt_done=0 and sqrt_available=1 in the same cycle, then state -> RESP. RELEASE has no timeout.
- RESP: rsp_valid=1 for one cycle with rsp_id/rsp_data/rsp_err; last_grant <= rsp_id; counter cleared; state -> IDLE. rsp_valid=0 in all other cycles.
- Minimum turnaround: engine done latency L cycles after START gives accept edge T, rsp_valid at T+L+2 (engine releases immediately). The next grant is possible at T+L+3.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other transactions.
- Counter width $clog2(TIMEOUT+1); saturating, no wrap.

Test Plan:
1. Reset then single request: req_valid=0001, req_data[0]=16, engine model done with out=4 after 6 cycles -> req_ready=0001 one cycle, sqrt_in=16, sqrt_start high until done, rsp_valid one cycle with rsp_id=0, rsp_data=4, rsp_err=0; busy low afterwards.
2. All four request simultaneously (operands 1,4,9,25) held until accepted -> grants in order 0,1,2,3, responses 1,2,3,5 with ids 0..3; re-raising req 0 and req 2 afterwards -> grant order 0 then 2.
3. Engine never asserts done, TIMEOUT=64 -> sqrt_start high exactly 64 BUSY cycles, then rsp_valid with rsp_err=1, rsp_data=0; the next request is served normally.
4. sqrt_available=0 while req_valid=0010 -> no req_ready and sqrt_start stays 0; available=1 -> grant on the next edge. Engine holding done high 3 cycles after start drops -> rsp_valid delayed until done=0.
5. rstn asserted mid-BUSY (asynchronously, between edges) -> sqrt_start, busy, and req_ready go 0 immediately with no response. After release, requests 1 and 3 pending -> requester 1 is granted first (last_grant reset to 3).
6. Requester withdraws req_valid before grant while another requests -> only the remaining requester is granted. Done on the same cycle the timeout counter hits TIMEOUT -> rsp_err=0 with the engine result.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
// Round-robin arbiter that shares a single square-root engine among N_REQ
// requesters. It takes one operand at a time and drives the engine's
// START/DONE/AVAILABLE handshake. Each result, or a timeout error, goes back
// to the originating requester as a one-cycle tagged response.
module sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [DATA_W-1:0]        sqrt_in,
  output logic                     sqrt_start,
  input  logic [DATA_W-1:0]        sqrt_out,
  input  logic                     sqrt_done,
  input  logic                     sqrt_available
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // The counter value seen on the edge that brings it up to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]        r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_REQ-1:0]  r_req_ready;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_busy;
  logic [DATA_W-1:0] r_sqrt_in;
  logic              r_sqrt_start;

  logic              w_any_req;
  logic [ID_W-1:0]   w_grant_id;
  logic [N_REQ-1:0]  w_grant_onehot;
  logic [DATA_W-1:0] w_grant_data;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_timeout;

  // Round-robin search that starts just after last_grant. The scan runs from
  // the lowest priority to the highest, so the last hit is the winner.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    v_idx      = '0;
    w_any_req  = 1'b0;
    w_grant_id = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      v_idx = ID_W'((int'(r_last_grant) + i) % N_REQ);
      if (req_valid[v_idx]) begin
        w_any_req  = 1'b1;
        w_grant_id = v_idx;
      end else begin
        w_any_req  = w_any_req;
        w_grant_id = w_grant_id;
      end
    end
  end

  assign w_grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant_id;
  assign w_grant_data   = req_data[w_grant_id*DATA_W +: DATA_W];

  // The counter saturates at TIMEOUT instead of wrapping.
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout  = (r_cnt >= CNT_LAST);

  // Sequencer FSM. All outputs are registered. Reset aborts any in-flight request silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_sqrt_in    <= '0;
      r_sqrt_start <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req && sqrt_available) begin
            r_req_ready  <= w_grant_onehot;
            r_sqrt_in    <= w_grant_data;
            r_rsp_id     <= w_grant_id;
            r_sqrt_start <= 1'b1;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_next;
          // DONE takes priority over a timeout on the same edge.
          if (sqrt_done) begin
            r_rsp_data   <= sqrt_out;
            r_rsp_err    <= 1'b0;
            r_sqrt_start <= 1'b0;
            r_state      <= S_RELEASE;
          end else if (w_timeout) begin
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b1;
            r_sqrt_start <= 1'b0;
            r_state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait for the engine to drop DONE and become available again.
          if (!sqrt_done && sqrt_available) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid  <= 1'b1;
          r_last_grant <= r_rsp_id;
          r_cnt        <= '0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_sqrt_start <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;
  assign sqrt_in    = r_sqrt_in;
  assign sqrt_start = r_sqrt_start;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter
// Directed bench for sqrt_arbiter. It uses a behavioural square-root engine
// with programmable done latency, a done-hold time, and a never-done mode.
module tb_sqrt_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    busy;
  logic [DATA_W-1:0]       sqrt_in;
  logic                    sqrt_start;
  logic [DATA_W-1:0]       sqrt_out;
  logic                    sqrt_done;
  logic                    sqrt_available;

  int n_checks = 0;
  int n_fail   = 0;

  // Engine model controls and state.
  int eng_lat       = 1;
  int eng_hold      = 0;
  int eng_cnt       = 0;
  int eng_hold_left = 0;
  bit eng_never     = 1'b0;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .sqrt_in(sqrt_in), .sqrt_start(sqrt_start), .sqrt_out(sqrt_out),
    .sqrt_done(sqrt_done), .sqrt_available(sqrt_available)
  );

  typedef struct {
    bit          pre_rst;
    logic [3:0]  valid;
    logic [127:0] data;
    int          lat;
    logic [3:0]  exp_ready;
    logic [31:0] exp_in;
    logic [1:0]  exp_id;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [63:0] r;
    r = 64'd0;
    while ((r + 64'd1) * (r + 64'd1) <= {32'd0, x}) r = r + 64'd1;
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock, then update the engine model from the DUT's new outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rstn) begin
      sqrt_done = 1'b0;
      eng_cnt   = 0;
    end else if (sqrt_done) begin
      if (!sqrt_start) begin
        if (eng_hold_left > 0) eng_hold_left--;
        else sqrt_done = 1'b0;
      end
    end else if (sqrt_start) begin
      eng_cnt++;
      if (!eng_never && eng_cnt >= eng_lat) begin
        sqrt_done     = 1'b1;
        sqrt_out      = isqrt(sqrt_in);
        eng_hold_left = eng_hold;
        eng_cnt       = 0;
      end
    end else begin
      eng_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    sqrt_done = 1'b0;
    eng_cnt   = 0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Run one transaction from request to response and check every handshake step.
  task automatic run_txn(input string name, input logic [3:0] valid, input logic [127:0] data,
                         input int lat, input int hold, input logic [3:0] exp_ready,
                         input logic [31:0] exp_in, input logic [1:0] exp_id,
                         input logic [31:0] exp_out, input logic exp_err,
                         input int exp_lat, input int exp_start);
    int n;
    int cyc;
    int starts;
    eng_lat   = lat;
    eng_hold  = hold;
    req_valid = valid;
    req_data  = data;
    n = 0;
    while (req_ready == 4'b0000 && n < 50) begin
      step();
      n++;
    end
    check({name, "_ready"}, req_ready, exp_ready);
    check({name, "_sqrt_in"}, sqrt_in, exp_in);
    check({name, "_busy_hi"}, busy, 1'b1);
    starts = sqrt_start ? 1 : 0;
    req_valid = valid & ~req_ready;
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      step();
      cyc++;
      if (cyc == 1) check({name, "_ready_pulse"}, req_ready, 4'b0000);
      if (sqrt_start) starts++;
    end
    check({name, "_rsp_valid"}, rsp_valid, 1'b1);
    check({name, "_rsp_id"}, rsp_id, exp_id);
    check({name, "_rsp_data"}, rsp_data, exp_out);
    check({name, "_rsp_err"}, rsp_err, exp_err);
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_start_cycles"}, starts, exp_start);
    check({name, "_busy_lo"}, busy, 1'b0);
    req_valid = '0;
    step();
    check({name, "_rsp_pulse"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int n_rsp;
    rstn           = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    sqrt_out       = 32'hDEAD_BEEF;
    sqrt_done      = 1'b0;
    sqrt_available = 1'b1;

    vecs[0] = '{1'b0, 4'b0001, {32'd0, 32'd0, 32'd0, 32'd16}, 6, 4'b0001, 32'd16, 2'd0, 32'd4};
    vecs[1] = '{1'b1, 4'b1111, {32'd25, 32'd9, 32'd4, 32'd1}, 1, 4'b0001, 32'd1, 2'd0, 32'd1};
    vecs[2] = '{1'b0, 4'b1110, {32'd25, 32'd9, 32'd4, 32'd1}, 3, 4'b0010, 32'd4, 2'd1, 32'd2};
    vecs[3] = '{1'b0, 4'b1100, {32'd25, 32'd9, 32'd4, 32'd1}, 2, 4'b0100, 32'd9, 2'd2, 32'd3};
    vecs[4] = '{1'b0, 4'b1000, {32'd25, 32'd9, 32'd4, 32'd1}, 5, 4'b1000, 32'd25, 2'd3, 32'd5};
    vecs[5] = '{1'b0, 4'b0101, {32'd25, 32'd9, 32'd4, 32'd1}, 2, 4'b0001, 32'd1, 2'd0, 32'd1};
    vecs[6] = '{1'b0, 4'b0100, {32'd25, 32'd9, 32'd4, 32'd1}, 2, 4'b0100, 32'd9, 2'd2, 32'd3};
    vecs[7] = '{1'b0, 4'b1011, {32'd25, 32'd9, 32'd4, 32'd1}, 4, 4'b1000, 32'd25, 2'd3, 32'd5};
    vecs[8] = '{1'b0, 4'b0011, {32'd25, 32'd9, 32'd4, 32'd1}, 2, 4'b0001, 32'd1, 2'd0, 32'd1};
    vecs[9] = '{1'b0, 4'b0010, {32'd25, 32'd9, 32'd4, 32'd1}, 1, 4'b0010, 32'd4, 2'd1, 32'd2};

    // Reset state.
    step();
    step();
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_id}, 4'b0000);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy_start", {busy, sqrt_start}, 2'b00);
    check("rst_sqrt_in", sqrt_in, 32'd0);
    rstn = 1'b1;

    // Table: single request, then the all-four round robin and re-raised requests.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_rst) do_reset();
      run_txn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].lat, 0,
              vecs[i].exp_ready, vecs[i].exp_in, vecs[i].exp_id, vecs[i].exp_out, 1'b0,
              vecs[i].lat + 2, vecs[i].lat);
    end

    // Engine never completes: abort after TIMEOUT BUSY cycles with an error.
    eng_never = 1'b1;
    sqrt_out  = 32'hDEAD_BEEF;
    run_txn("timeout", 4'b0010, {32'd0, 32'd0, 32'd49, 32'd0}, 1, 0,
            4'b0010, 32'd49, 2'd1, 32'd0, 1'b1, 66, 64);
    eng_never = 1'b0;
    run_txn("after_to", 4'b0001, {32'd0, 32'd0, 32'd0, 32'd64}, 4, 0,
            4'b0001, 32'd64, 2'd0, 32'd8, 1'b0, 6, 4);

    // Engine unavailable holds off the grant; done held after start delays the response.
    sqrt_available = 1'b0;
    req_data  = {32'd0, 32'd0, 32'd169, 32'd0};
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("unavail%0d", i), {req_ready, sqrt_start, busy}, 6'b000000);
    end
    eng_lat        = 2;
    eng_hold       = 3;
    sqrt_available = 1'b1;
    step();
    check("avail_grant", req_ready, 4'b0010);
    run_txn("hold", 4'b0010, {32'd0, 32'd0, 32'd169, 32'd0}, 2, 3,
            4'b0010, 32'd169, 2'd1, 32'd13, 1'b0, 7, 2);

    // Asynchronous reset in the middle of BUSY.
    eng_lat   = 20;
    eng_hold  = 0;
    req_data  = {32'd0, 32'd81, 32'd0, 32'd0};
    req_valid = 4'b0100;
    step();
    check("midrst_grant", req_ready, 4'b0100);
    req_valid = '0;
    step();
    step();
    check("midrst_busy", {busy, sqrt_start}, 2'b11);
    #3;
    rstn = 1'b0;
    #1;
    check("midrst_async", {sqrt_start, busy, req_ready}, 6'b000000);
    check("midrst_sqrt_in", sqrt_in, 32'd0);
    step();
    step();
    rstn = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (rsp_valid) n_rsp++;
    end
    check("midrst_no_rsp", n_rsp, 0);
    run_txn("postrst1", 4'b1010, {32'd100, 32'd0, 32'd36, 32'd0}, 3, 0,
            4'b0010, 32'd36, 2'd1, 32'd6, 1'b0, 5, 3);
    run_txn("postrst3", 4'b1000, {32'd100, 32'd0, 32'd36, 32'd0}, 2, 0,
            4'b1000, 32'd100, 2'd3, 32'd10, 1'b0, 4, 2);

    // Withdrawn request is never granted; done on the timeout edge wins.
    sqrt_available = 1'b0;
    req_data  = {32'd0, 32'd0, 32'd144, 32'd121};
    req_valid = 4'b0011;
    step();
    step();
    check("wd_wait", req_ready, 4'b0000);
    req_valid = 4'b0010;
    step();
    check("wd_wait2", req_ready, 4'b0000);
    sqrt_available = 1'b1;
    run_txn("wd_done_at_to", 4'b0010, {32'd0, 32'd0, 32'd144, 32'd121}, 64, 0,
            4'b0010, 32'd144, 2'd1, 32'd12, 1'b0, 66, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
